fetch_engine: RTL and testbench

FETCH_ENGINE -- requirements
Module: fetch_engine

---
 rtl/fetch_engine.sv | 181 ++++++++++++++++++
 tb/tb_fetch_engine.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_engine.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_engine
//  Description : Single-outstanding memory read engine. Accepts a fetch
//                request (start address, word count), issues one 32-bit read
//                at a time, and forwards each returned word to a data FIFO.
//                A separate room counter tracks unreserved FIFO space.
//  Options     : FETCH_ENGINE_ERR_EN - when defined, err is a sticky flag
//                raised on room clamp or on stray read data; otherwise err
//                is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_engine #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic        fetch_data,
  input  logic [31:0] addr_data,
  input  logic [7:0]  length_data,
  output logic        ack_fetch_data,
  input  logic        subtract_room,
  output logic [7:0]  datafifo_room,
  output logic        mem_rd_req,
  output logic [31:0] mem_rd_addr,
  input  logic        mem_rd_gnt,
  input  logic        mem_rd_valid,
  input  logic [31:0] mem_rd_data,
  output logic        dfifo_wr,
  output logic [31:0] dfifo_wdata,
  input  logic        dfifo_pop,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ACK       = 2'd1,
    S_ISSUE     = 2'd2,
    S_WAIT_DATA = 2'd3
  } state_t;

  // Room arithmetic is carried one bit wider than a 9-bit signed value so
  // that a full counter at the maximum depth plus a pop cannot wrap negative.
  localparam logic signed [9:0] c_room_max   = 10'(FIFO_DEPTH);
  localparam logic [7:0]        c_room_reset = 8'(FIFO_DEPTH);

  state_t            r_state;
  state_t            w_next_state;
  logic [31:0]       r_cur_addr;
  logic [31:0]       w_cur_addr_next;
  logic [7:0]        r_cur_len;
  logic [7:0]        w_cur_len_next;
  logic              r_after_ack;
  logic              w_take_data;
  logic signed [9:0] w_room_sum;
  logic              w_room_under;
  logic              w_room_over;
  logic [7:0]        w_room_next;

  // State register
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and transfer bookkeeping
  always_comb begin
    w_next_state    = r_state;
    w_cur_addr_next = r_cur_addr;
    w_cur_len_next  = r_cur_len;
    w_take_data     = 1'b0;
    case (r_state)
      S_IDLE: begin
        // The IDLE cycle straight after ACK ignores a request still held high.
        if (fetch_data && !r_after_ack) begin
          w_cur_addr_next = addr_data;
          w_cur_len_next  = length_data;
          w_next_state    = S_ACK;
        end
      end
      S_ACK: begin
        w_next_state = (r_cur_len != 8'd0) ? S_ISSUE : S_IDLE;
      end
      S_ISSUE: begin
        if (mem_rd_gnt) begin
          w_next_state = S_WAIT_DATA;
        end
      end
      S_WAIT_DATA: begin
        if (mem_rd_valid) begin
          w_take_data     = 1'b1;
          w_cur_addr_next = r_cur_addr + 32'd4;
          w_cur_len_next  = r_cur_len - 8'd1;
          w_next_state    = (r_cur_len == 8'd1) ? S_IDLE : S_ISSUE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Registered outputs and transfer registers, all derived from next state
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_cur_addr     <= 32'd0;
      r_cur_len      <= 8'd0;
      r_after_ack    <= 1'b0;
      ack_fetch_data <= 1'b0;
      busy           <= 1'b0;
      mem_rd_req     <= 1'b0;
      mem_rd_addr    <= 32'd0;
      dfifo_wr       <= 1'b0;
      dfifo_wdata    <= 32'd0;
    end else begin
      r_cur_addr     <= w_cur_addr_next;
      r_cur_len      <= w_cur_len_next;
      r_after_ack    <= (r_state == S_ACK);
      ack_fetch_data <= (w_next_state == S_ACK);
      busy           <= (w_next_state != S_IDLE);
      mem_rd_req     <= (w_next_state == S_ISSUE);
      if (w_next_state == S_ISSUE) begin
        mem_rd_addr <= w_cur_addr_next;
      end
      dfifo_wr <= w_take_data;
      if (w_take_data) begin
        dfifo_wdata <= mem_rd_data;
      end
    end
  end

  // Room counter: reserve on subtract_room, release on dfifo_pop, clamp to range
  always_comb begin
    w_room_sum = $signed({2'b00, datafifo_room});
    if (subtract_room) begin
      w_room_sum = w_room_sum - $signed({2'b00, length_data});
    end
    if (dfifo_pop) begin
      w_room_sum = w_room_sum + 10'sd1;
    end
    w_room_under = (w_room_sum < 10'sd0);
    w_room_over  = (w_room_sum > c_room_max);
    w_room_next  = w_room_sum[7:0];
    if (w_room_under) begin
      w_room_next = 8'd0;
    end else if (w_room_over) begin
      w_room_next = c_room_reset;
    end
  end

  // Room register, independent of the fetch state machine
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      datafifo_room <= c_room_reset;
    end else begin
      datafifo_room <= w_room_next;
    end
  end

`ifdef FETCH_ENGINE_ERR_EN
  logic w_stray_valid;
  assign w_stray_valid = mem_rd_valid && (r_state != S_WAIT_DATA);

  // Sticky error: room clamp or read data arriving when none is expected
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      err <= 1'b0;
    end else if (w_room_under || w_room_over || w_stray_valid) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_engine
//  Description : Self-checking bench for fetch_engine: table-driven room
//                counter vectors plus directed fetch sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_engine;

`ifdef FETCH_ENGINE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk           = 1'b0;
  logic        rstb          = 1'b0;
  logic        fetch_data    = 1'b0;
  logic [31:0] addr_data     = 32'd0;
  logic [7:0]  length_data   = 8'd0;
  logic        ack_fetch_data;
  logic        subtract_room = 1'b0;
  logic [7:0]  datafifo_room;
  logic        mem_rd_req;
  logic [31:0] mem_rd_addr;
  logic        mem_rd_gnt    = 1'b0;
  logic        mem_rd_valid  = 1'b0;
  logic [31:0] mem_rd_data   = 32'd0;
  logic        dfifo_wr;
  logic [31:0] dfifo_wdata;
  logic        dfifo_pop     = 1'b0;
  logic        busy;
  logic        err;

  int checks   = 0;
  int failures = 0;

  int ack_cnt = 0;
  int wr_cnt  = 0;
  int req_cyc = 0;
  int gnt_cnt = 0;

  fetch_engine #(.FIFO_DEPTH(8)) dut (
    .clk            (clk),
    .rstb           (rstb),
    .fetch_data     (fetch_data),
    .addr_data      (addr_data),
    .length_data    (length_data),
    .ack_fetch_data (ack_fetch_data),
    .subtract_room  (subtract_room),
    .datafifo_room  (datafifo_room),
    .mem_rd_req     (mem_rd_req),
    .mem_rd_addr    (mem_rd_addr),
    .mem_rd_gnt     (mem_rd_gnt),
    .mem_rd_valid   (mem_rd_valid),
    .mem_rd_data    (mem_rd_data),
    .dfifo_wr       (dfifo_wr),
    .dfifo_wdata    (dfifo_wdata),
    .dfifo_pop      (dfifo_pop),
    .busy           (busy),
    .err            (err)
  );

  always #5 clk = ~clk;

  // Event counters sampled mid-cycle
  always @(negedge clk) begin
    if (ack_fetch_data)           ack_cnt = ack_cnt + 1;
    if (dfifo_wr)                 wr_cnt  = wr_cnt + 1;
    if (mem_rd_req)               req_cyc = req_cyc + 1;
    if (mem_rd_req && mem_rd_gnt) gnt_cnt = gnt_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       sub;
    logic [7:0] len;
    logic       pop;
    logic [7:0] room;
    logic       err_if_en;
  } room_vec_t;

  room_vec_t vecs [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rstb = 1'b0;
    tick();
    tick();
    rstb = 1'b1;
    tick();
  endtask

  task automatic start_fetch(input logic [31:0] a, input logic [7:0] l, input bit hold);
    fetch_data  = 1'b1;
    addr_data   = a;
    length_data = l;
    tick();
    chk("ack_pulse", {31'd0, ack_fetch_data}, 32'd1);
    chk("ack_busy", {31'd0, busy}, 32'd1);
    if (!hold) fetch_data = 1'b0;
  endtask

  // Memory responder: hold grant low gnt_wait cycles, return data vlat cycles after grant
  task automatic serve_reads(input int n, input logic [31:0] base, input int gnt_wait,
                             input int vlat, input logic [31:0] dbase);
    logic [31:0] ea;
    logic [31:0] ed;
    int          t;
    for (int i = 0; i < n; i++) begin
      ea = base + 32'(4 * i);
      ed = dbase + 32'(i);
      t  = 0;
      while (!mem_rd_req && t < 50) begin
        tick();
        t++;
      end
      chk("req_seen", {31'd0, mem_rd_req}, 32'd1);
      for (int k = 0; k < gnt_wait; k++) begin
        chk("req_hold", {31'd0, mem_rd_req}, 32'd1);
        chk("addr_hold", mem_rd_addr, ea);
        tick();
      end
      chk("rd_addr", mem_rd_addr, ea);
      mem_rd_gnt = 1'b1;
      tick();
      mem_rd_gnt = 1'b0;
      chk("req_drop", {31'd0, mem_rd_req}, 32'd0);
      for (int k = 1; k < vlat; k++) tick();
      mem_rd_valid = 1'b1;
      mem_rd_data  = ed;
      tick();
      mem_rd_valid = 1'b0;
      mem_rd_data  = 32'd0;
      chk("wr_strobe", {31'd0, dfifo_wr}, 32'd1);
      chk("wr_data", dfifo_wdata, ed);
    end
  endtask

  initial begin
    int a0;
    int w0;
    int g0;
    int r0;

    // Room vectors applied in order from reset (room 8); expected values hand-computed
    vecs[0]  = '{1'b1, 8'd3, 1'b0, 8'd5, 1'b0};
    vecs[1]  = '{1'b0, 8'd0, 1'b1, 8'd6, 1'b0};
    vecs[2]  = '{1'b1, 8'd2, 1'b1, 8'd5, 1'b0};
    vecs[3]  = '{1'b0, 8'd5, 1'b0, 8'd5, 1'b0};
    vecs[4]  = '{1'b0, 8'd0, 1'b1, 8'd6, 1'b0};
    vecs[5]  = '{1'b0, 8'd0, 1'b1, 8'd7, 1'b0};
    vecs[6]  = '{1'b0, 8'd0, 1'b1, 8'd8, 1'b0};
    vecs[7]  = '{1'b1, 8'd8, 1'b0, 8'd0, 1'b0};
    vecs[8]  = '{1'b1, 8'd8, 1'b1, 8'd0, 1'b1};
    vecs[9]  = '{1'b0, 8'd0, 1'b1, 8'd1, 1'b1};
    vecs[10] = '{1'b1, 8'd1, 1'b1, 8'd1, 1'b1};
    vecs[11] = '{1'b1, 8'd0, 1'b0, 8'd1, 1'b1};

    // Reset state, observed while reset is held
    tick();
    tick();
    chk("rst_ack", {31'd0, ack_fetch_data}, 32'd0);
    chk("rst_req", {31'd0, mem_rd_req}, 32'd0);
    chk("rst_addr", mem_rd_addr, 32'd0);
    chk("rst_wr", {31'd0, dfifo_wr}, 32'd0);
    chk("rst_wdata", dfifo_wdata, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_room", {24'd0, datafifo_room}, 32'd8);
    rstb = 1'b1;
    tick();
    chk("post_rst_room", {24'd0, datafifo_room}, 32'd8);

    // Room counter table
    for (int i = 0; i < 12; i++) begin
      subtract_room = vecs[i].sub;
      length_data   = vecs[i].len;
      dfifo_pop     = vecs[i].pop;
      tick();
      subtract_room = 1'b0;
      dfifo_pop     = 1'b0;
      length_data   = 8'd0;
      chk($sformatf("room_vec%0d", i), {24'd0, datafifo_room}, {24'd0, vecs[i].room});
      chk($sformatf("err_vec%0d", i), {31'd0, err}, {31'd0, vecs[i].err_if_en & ERR_EN});
    end

    // Overflow clamp from a full counter
    do_reset();
    chk("ovf_pre_err", {31'd0, err}, 32'd0);
    dfifo_pop = 1'b1;
    tick();
    dfifo_pop = 1'b0;
    chk("ovf_room", {24'd0, datafifo_room}, 32'd8);
    chk("ovf_err", {31'd0, err}, {31'd0, ERR_EN});
    do_reset();

    // Three-word fetch, immediate grant, data two cycles after grant
    a0 = ack_cnt; w0 = wr_cnt; g0 = gnt_cnt;
    start_fetch(32'h0000_1000, 8'd3, 1'b0);
    tick();
    chk("req_latency", {31'd0, mem_rd_req}, 32'd1);
    chk("first_addr", mem_rd_addr, 32'h0000_1000);
    serve_reads(3, 32'h0000_1000, 0, 2, 32'hA5A5_0000);
    chk("t1_busy_end", {31'd0, busy}, 32'd0);
    chk("t1_req_end", {31'd0, mem_rd_req}, 32'd0);
    tick();
    chk("t1_ack_count", 32'(ack_cnt - a0), 32'd1);
    chk("t1_wr_count", 32'(wr_cnt - w0), 32'd3);
    chk("t1_gnt_count", 32'(gnt_cnt - g0), 32'd3);

    // Zero-length fetch with the request held past the acknowledge
    a0 = ack_cnt; r0 = req_cyc;
    start_fetch(32'h0000_5000, 8'd0, 1'b1);
    tick();
    chk("zl_ack_gone", {31'd0, ack_fetch_data}, 32'd0);
    chk("zl_idle", {31'd0, busy}, 32'd0);
    tick();
    chk("zl_ignore_busy", {31'd0, busy}, 32'd0);
    chk("zl_ignore_ack", {31'd0, ack_fetch_data}, 32'd0);
    fetch_data = 1'b0;
    tick();
    chk("zl_ack_count", 32'(ack_cnt - a0), 32'd1);
    chk("zl_req_cycles", 32'(req_cyc - r0), 32'd0);

    // Grant withheld for five cycles
    w0 = wr_cnt; g0 = gnt_cnt;
    start_fetch(32'h0000_2000, 8'd1, 1'b0);
    serve_reads(1, 32'h0000_2000, 5, 1, 32'h1234_5678);
    chk("gw_busy_end", {31'd0, busy}, 32'd0);
    tick();
    chk("gw_gnt_count", 32'(gnt_cnt - g0), 32'd1);
    chk("gw_wr_count", 32'(wr_cnt - w0), 32'd1);

    // Address wrap at the top of the 32-bit space
    start_fetch(32'hFFFF_FFFC, 8'd2, 1'b0);
    serve_reads(2, 32'hFFFF_FFFC, 1, 3, 32'hC0DE_0000);
    chk("wrap_busy_end", {31'd0, busy}, 32'd0);

    // Reset during WAIT_DATA, stale data after release
    subtract_room = 1'b1;
    length_data   = 8'd3;
    tick();
    subtract_room = 1'b0;
    chk("mid_room_pre", {24'd0, datafifo_room}, 32'd5);
    start_fetch(32'h0000_3000, 8'd4, 1'b0);
    tick();
    chk("mid_req", {31'd0, mem_rd_req}, 32'd1);
    mem_rd_gnt = 1'b1;
    tick();
    mem_rd_gnt = 1'b0;
    chk("mid_busy", {31'd0, busy}, 32'd1);
    w0 = wr_cnt;
    rstb = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_room", {24'd0, datafifo_room}, 32'd8);
    tick();
    rstb = 1'b1;
    mem_rd_valid = 1'b1;
    mem_rd_data  = 32'hDEAD_BEEF;
    tick();
    mem_rd_valid = 1'b0;
    mem_rd_data  = 32'd0;
    chk("mid_drop_wr", {31'd0, dfifo_wr}, 32'd0);
    chk("mid_idle", {31'd0, busy}, 32'd0);
    tick();
    chk("mid_wr_count", 32'(wr_cnt - w0), 32'd0);
    chk("mid_req_idle", {31'd0, mem_rd_req}, 32'd0);
    chk("mid_room", {24'd0, datafifo_room}, 32'd8);
    chk("mid_stray_err", {31'd0, err}, {31'd0, ERR_EN});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
